ft_module: RTL and testbench

//  Lock-step fault-tolerance unit for a dual-core (A/B) RISC-V pair.
//  - Compares both cores' register-file write ports every cycle.
//  - Keeps a safe-PC checkpoint (SPC) of the last agreed PC.
//  - On divergence: pulses a core reset, then holds recover until the cores report done.
//  - Also serves as the pair's shared single-port data memory (OBI-like request/grant/rvalid).

---
 rtl/ft_module.sv | 142 ++++++++++++++
 tb/tb_ft_module.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ft_module.sv
// ft_module
//   Lock-step fault-tolerance unit for a dual-core (A/B) RISC-V pair, plus the
//   pair's shared single-port data memory.
//
//   Fault handling:
//     - Both cores' register-file write ports are compared every cycle.
//     - The safe PC (SPC) follows pc_i while the pair agrees in IDLE.
//     - A divergence starts a core reset pulse of RESET_CYCLES cycles.
//     - recover_o is then held until done_i is sampled.
//
//   Ports:
//     clk_i, rst_ni            clock and async active-low reset
//     we/addr/data_{a,b}_i     register-file write ports of cores A and B
//     enable_i                 comparator enable
//     pc_i                     committed PC of the pair
//     spc_o                    checkpointed safe PC
//     reset_o, recover_o       core reset pulse and restore request
//     done_i                   cores finished restoring from the SPC
//     data_*                   OBI-like memory port (req/gnt/rvalid)
module ft_module #(
    parameter int          DMEM_WORDS   = 1024,
    parameter int          RESET_CYCLES = 4,
    parameter logic [31:0] BOOT_PC      = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [5:0]  addr_a_i,
    input  logic [5:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic        enable_i,
    input  logic [31:0] pc_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        done_i,
    output logic        recover_o,
    output logic        reset_o,
    output logic [31:0] spc_o
);

    localparam int AW = $clog2(DMEM_WORDS);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RST, RECOVER} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mismatch;

    // Addresses and data only matter when both cores actually write.
    assign mismatch = enable_i &&
                      ((we_a_i != we_b_i) ||
                       (we_a_i && we_b_i &&
                        ((addr_a_i != addr_b_i) || (data_a_i != data_b_i))));

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        reset_o   = 1'b0;
        recover_o = 1'b0;
        case (state)
            IDLE: begin
                if (mismatch) begin
                    state_n = RST;
                    cnt_n   = '0;
                end
            end
            RST: begin
                reset_o = 1'b1;
                if (cnt == CNT_LAST) state_n = RECOVER;
                else                 cnt_n   = cnt + 1'b1;
            end
            RECOVER: begin
                recover_o = 1'b1;
                if (done_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Only an agreeing pair in IDLE may advance the checkpoint.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                  spc_o <= BOOT_PC;
        else if (state == IDLE && enable_i && !mismatch) spc_o <= pc_i;
    end

    // ---------------- data memory ----------------
    logic [31:0]   mem [DMEM_WORDS];
    logic [29:0]   widx;
    logic [AW-1:0] midx;
    logic          in_range;
    logic          unused_lsb;

    assign widx       = data_addr_i[31:2];
    assign midx       = widx[AW-1:0];
    assign in_range   = widx < 30'(DMEM_WORDS);
    assign unused_lsb = ^data_addr_i[1:0];
    assign data_gnt_o = data_req_i;

    // No reset on the array: contents are undefined after reset.
    always_ff @(posedge clk_i) begin
        if (data_req_i && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++)
                if (data_be_i[b]) mem[midx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
    end

    // Registered read: a write on edge N is visible to a read granted on N+1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            data_rvalid_o <= data_req_i;
            data_err_o    <= data_req_i && !in_range;
            data_rdata_o  <= (data_req_i && !data_we_i && in_range) ? mem[midx] : '0;
        end
    end

endmodule

// File: tb/tb_ft_module.sv
module tb_ft_module;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        we_a, we_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        enable;
    logic [31:0] pc;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        done, recover, reset_c;
    logic [31:0] spc;

    ft_module dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .we_a_i(we_a), .we_b_i(we_b), .addr_a_i(addr_a), .addr_b_i(addr_b),
        .data_a_i(data_a), .data_b_i(data_b), .enable_i(enable), .pc_i(pc),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .done_i(done), .recover_o(recover), .reset_o(reset_c), .spc_o(spc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_ni && data_rvalid) begin
            if (q.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
                chk("err", {31'd0, data_err}, {31'd0, e.err});
                if (e.chk_data) chk("rdata", data_rdata, e.rdata);
            end
        end
    end

    // Memory vectors, issued back to back.
    localparam int NV = 13;
    logic        v_we   [NV] = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [3:0]  v_be   [NV] = '{4'hF, 4'hF, 4'h3, 4'h0, 4'h0, 4'hF, 4'h0,
                                 4'hF, 4'h0, 4'hC, 4'h0, 4'hF, 4'h0};
    logic [31:0] v_addr [NV] = '{32'h10, 32'h0, 32'h10, 32'h10, 32'h1000, 32'h1000,
                                 32'h0, 32'h14, 32'h14, 32'h10, 32'h10, 32'hFFC, 32'hFFC};
    logic [31:0] v_wd   [NV] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hFFFFFFFF,
                                 32'h0, 32'h12345678, 32'h0, 32'hAAAA5555, 32'h0,
                                 32'hCAFEF00D, 32'h0};
    logic [31:0] v_rd   [NV] = '{32'h0, 32'h0, 32'h0, 32'h0000BEEF, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h12345678, 32'h0, 32'hAAAABEEF,
                                 32'h0, 32'hCAFEF00D};
    logic        v_err  [NV] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst_ni = 0; we_a = 0; we_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
        enable = 0; pc = 0; data_req = 0; data_we = 0; data_be = 0; data_addr = 0;
        data_wdata = 0; done = 0;

        // Reset state
        #12;
        chk("rst_reset_o", {31'd0, reset_c}, 32'd0);
        chk("rst_recover_o", {31'd0, recover}, 32'd0);
        chk("rst_rvalid", {31'd0, data_rvalid}, 32'd0);
        chk("rst_err", {31'd0, data_err}, 32'd0);
        chk("rst_spc", spc, 32'h80);
        rst_ni = 1;

        // Agreeing writes advance the SPC
        @(posedge clk); #1;
        enable = 1; we_a = 1; we_b = 1; addr_a = 6'h0A; addr_b = 6'h0A;
        data_a = 32'h6; data_b = 32'h6; pc = 32'h100;
        @(negedge clk);
        chk("agree_spc_before", spc, 32'h80);
        chk("agree_reset_o", {31'd0, reset_c}, 32'd0);
        @(negedge clk);
        chk("agree_spc", spc, 32'h100);
        chk("agree_reset_o2", {31'd0, reset_c}, 32'd0);

        // Mismatch: only A writes
        @(posedge clk); #1;
        we_b = 0; pc = 32'h200;
        @(negedge clk);
        chk("mm_reset_latency", {31'd0, reset_c}, 32'd0);
        @(posedge clk); #1;
        pc = 32'h300;   // mismatch persists: must be ignored outside IDLE
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_pulse", {31'd0, reset_c}, 32'd1);
            chk("rst_no_recover", {31'd0, recover}, 32'd0);
            chk("rst_spc_frozen", spc, 32'h100);
        end
        @(negedge clk);
        chk("rst_pulse_end", {31'd0, reset_c}, 32'd0);
        chk("recover_on", {31'd0, recover}, 32'd1);
        chk("recover_spc_frozen", spc, 32'h100);
        @(negedge clk);
        chk("recover_hold", {31'd0, recover}, 32'd1);

        // Recover handshake
        @(posedge clk); #1;
        done = 1;
        @(negedge clk);
        chk("recover_done_cycle", {31'd0, recover}, 32'd1);
        @(posedge clk); #1;
        done = 0; we_a = 0;
        @(negedge clk);
        chk("recover_off", {31'd0, recover}, 32'd0);
        chk("idle_reset_o", {31'd0, reset_c}, 32'd0);

        // Comparator disabled
        @(posedge clk); #1;
        enable = 0; we_a = 1; we_b = 1; data_a = 32'h1; data_b = 32'h2; pc = 32'h400;
        @(negedge clk);
        chk("dis_spc", spc, 32'h300);
        @(negedge clk);
        chk("dis_reset_o", {31'd0, reset_c}, 32'd0);
        chk("dis_spc_frozen", spc, 32'h300);
        @(negedge clk);
        chk("dis_reset_o2", {31'd0, reset_c}, 32'd0);
        @(posedge clk); #1;
        we_a = 0; we_b = 0; enable = 1;

        // Memory, back to back
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            data_req = 1; data_we = v_we[i]; data_be = v_be[i];
            data_addr = v_addr[i]; data_wdata = v_wd[i];
            q.push_back('{rdata: v_rd[i], chk_data: !v_we[i], err: v_err[i], cyc: cyc + 1});
            #1 chk("gnt", {31'd0, data_gnt}, 32'd1);
        end
        @(posedge clk); #1;
        data_req = 0;
        #1 chk("gnt_idle", {31'd0, data_gnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);

        // Reset in the middle of RST with a read in flight
        @(posedge clk); #1;
        we_a = 1;
        @(posedge clk); #1;
        we_a = 0; data_req = 1; data_we = 0; data_addr = 32'h10;
        @(negedge clk);
        chk("mid_reset_o", {31'd0, reset_c}, 32'd1);
        @(posedge clk); #1;
        data_req = 0;
        rst_ni = 0;
        #1;
        chk("mid_rvalid_drop", {31'd0, data_rvalid}, 32'd0);
        chk("mid_reset_o_clr", {31'd0, reset_c}, 32'd0);
        chk("mid_recover_clr", {31'd0, recover}, 32'd0);
        chk("mid_spc_boot", spc, 32'h80);
        #10 rst_ni = 1;
        @(negedge clk);
        chk("post_reset_o", {31'd0, reset_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
